// File: rtl/b_update_pe.sv
// b_update_pe: lane-parallel SCAN B-message update, pairs a/c beats into one 2*P*Q write beat.
module b_update_pe #(
  parameter int Q  = 6,
  parameter int P  = 64,
  parameter int LW = 5,
  parameter int CW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_in,
  input  logic              sel_in,
  input  logic [P*Q-1:0]    b_rd,
  input  logic [P*Q-1:0]    l_in,
  input  logic [LW-1:0]     layer_in,
  input  logic [CW-1:0]     cnt_in,
  output logic [2*P*Q-1:0]  b_wr,
  output logic              w_en,
  output logic [LW-1:0]     layer_w,
  output logic [CW-1:0]     cnta,
  output logic              pend,
  output logic              err
);
  localparam logic [Q-1:0] MX = {1'b0, {(Q-1){1'b1}}};
  localparam logic [Q-1:0] MN = {1'b1, {(Q-1){1'b0}}};
  typedef enum logic {IDLE, HOLD} st_t;
  st_t st, st_n;
  logic cap_a, go, bad;
  logic [P*Q-1:0] a_r, a0, c0, l0, a1, c1, s1, m1, s_c, m_c, up_c, lo_c;
  logic [LW-1:0] ly0, ly1;
  logic [CW-1:0] ct0, ct1;
  logic v0, v1;
  function automatic logic [Q-1:0] mag(input logic [Q-1:0] x);
    mag = x[Q-1] ? ((x == MN) ? MX : -x) : x;
  endfunction
  function automatic logic [Q-1:0] fm(input logic [Q-1:0] x, input logic [Q-1:0] y);
    logic [Q-1:0] m;
    m = (mag(x) < mag(y)) ? mag(x) : mag(y);
    fm = (x[Q-1] ^ y[Q-1]) ? -m : m;
  endfunction
  // Symmetric saturation keeps -2^(Q-1) out of every result.
  function automatic logic [Q-1:0] sat(input logic [Q-1:0] x, input logic [Q-1:0] y);
    logic signed [Q:0] t;
    t = $signed({x[Q-1], x}) + $signed({y[Q-1], y});
    sat = (t > $signed({1'b0, MX})) ? MX : (t < -$signed({1'b0, MX})) ? -MX : t[Q-1:0];
  endfunction
  always_comb begin
    st_n  = vld_in ? (sel_in ? IDLE : HOLD) : st;
    cap_a = vld_in & ~sel_in;
    go    = vld_in & sel_in & (st == HOLD);
    bad   = vld_in & sel_in & (st == IDLE);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= IDLE;
    else st <= st_n;
  end
  assign pend = (st == HOLD);
  for (genvar i = 0; i < P; i++) begin : g_lane
    assign s_c[i*Q +: Q]  = sat(c0[i*Q +: Q], l0[i*Q +: Q]);
    assign m_c[i*Q +: Q]  = fm(a0[i*Q +: Q], l0[i*Q +: Q]);
    assign up_c[i*Q +: Q] = fm(a1[i*Q +: Q], s1[i*Q +: Q]);
    assign lo_c[i*Q +: Q] = sat(c1[i*Q +: Q], m1[i*Q +: Q]);
  end
  // Operands are snapshotted at launch so a following `a` can reuse a_r immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
      a_r <= '0;
      {v0, a0, c0, l0, ly0, ct0} <= '0;
      {v1, a1, c1, s1, m1, ly1, ct1} <= '0;
      {w_en, b_wr, layer_w, cnta} <= '0;
    end else begin
      err <= err | bad;
      if (cap_a) a_r <= b_rd;
      v0 <= go;
      v1 <= v0;
      w_en <= v1;
      if (go) {a0, c0, l0, ly0, ct0} <= {a_r, b_rd, l_in, layer_in, cnt_in};
      if (v0) {a1, c1, s1, m1, ly1, ct1} <= {a0, c0, s_c, m_c, ly0, ct0};
      if (v1) {b_wr, layer_w, cnta} <= {lo_c, up_c, ly1, ct1};
    end
  end
endmodule

// File: tb/tb_b_update_pe.sv
// tb_b_update_pe: scoreboard bench for b_update_pe with hand-computed directed vectors.
module tb_b_update_pe;
  localparam int Q = 6, P = 64, LW = 5, CW = 4;
  logic clk = 0, rst = 0, vld_in = 0, sel_in = 0;
  logic [P*Q-1:0] b_rd = '0, l_in = '0;
  logic [LW-1:0] layer_in = '0;
  logic [CW-1:0] cnt_in = '0;
  logic [2*P*Q-1:0] b_wr;
  logic w_en, pend, err;
  logic [LW-1:0] layer_w;
  logic [CW-1:0] cnta;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {
    logic [2*P*Q-1:0] b;
    logic [LW-1:0] ly;
    logic [CW-1:0] ct;
    int cy;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int ta[8]  = '{5, -20, -32, 2, 10, -7, 0, 31};
  int tc[8]  = '{3, 31, 0, 0, -10, -31, 4, -16};
  int tl[8]  = '{-7, 31, -32, 5, -5, -31, -9, 20};
  int tu[8]  = '{-4, -20, 31, 2, -10, 7, 0, 4};
  int tlo[8] = '{-2, 11, 31, 2, -15, -24, 4, 4};

  b_update_pe #(.Q(Q), .P(P), .LW(LW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .sel_in(sel_in), .b_rd(b_rd), .l_in(l_in),
    .layer_in(layer_in), .cnt_in(cnt_in), .b_wr(b_wr), .w_en(w_en), .layer_w(layer_w),
    .cnta(cnta), .pend(pend), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (w_en) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_wen cyc=%0d cnta=%0d", cyc, cnta);
      end else begin
        e = q.pop_front();
        if (b_wr !== e.b || layer_w !== e.ly || cnta !== e.ct || cyc != e.cy) begin
          errors++;
          $display("FAIL beat got b=%h ly=%0d ct=%0d cyc=%0d want b=%h ly=%0d ct=%0d cyc=%0d",
                   b_wr, layer_w, cnta, cyc, e.b, e.ly, e.ct, e.cy);
        end
      end
    end
  end

  function automatic logic [P*Q-1:0] rep(input int v);
    for (int i = 0; i < P; i++) rep[i*Q +: Q] = v[Q-1:0];
  endfunction
  function automatic logic [P*Q-1:0] lane2(input int v0, input int vl);
    lane2 = '0;
    lane2[Q-1:0] = v0[Q-1:0];
    lane2[(P-1)*Q +: Q] = vl[Q-1:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask
  task automatic beat(input logic s, input logic [P*Q-1:0] b, input logic [P*Q-1:0] l,
                      input logic [LW-1:0] ly, input logic [CW-1:0] ct);
    @(posedge clk);
    #1;
    vld_in = 1; sel_in = s; b_rd = b; l_in = l; layer_in = ly; cnt_in = ct;
  endtask
  task automatic cbeat(input logic [P*Q-1:0] c, input logic [P*Q-1:0] l, input logic [LW-1:0] ly,
                       input logic [CW-1:0] ct, input logic [P*Q-1:0] up, input logic [P*Q-1:0] lo);
    exp_t x;
    beat(1, c, l, ly, ct);
    x.b = {lo, up}; x.ly = ly; x.ct = ct; x.cy = cyc + 3;
    q.push_back(x);
  endtask
  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      vld_in = 0;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_w_en", w_en, 0);
    chk("rst_b_wr", |b_wr, 0);
    chk("rst_tags", {layer_w, cnta}, 0);
    chk("rst_pend", pend, 0);
    chk("rst_err", err, 0);
    rst = 1;
    beat(0, rep(5), '0, 0, 0);
    cbeat(rep(3), rep(-7), 3, 2, rep(-4), rep(-2));
    beat(0, rep(-20), '0, 0, 0);
    cbeat(rep(31), rep(31), 4, 5, rep(-20), rep(11));
    beat(0, rep(-32), '0, 0, 0);
    cbeat(rep(0), rep(-32), 6, 7, rep(31), rep(31));
    beat(0, lane2(1, -3), '0, 0, 0);
    cbeat(lane2(1, -2), lane2(1, 4), 1, 1, lane2(1, -2), lane2(2, -5));
    gap(5);
    chk("err_clean", err, 0);
    chk("pend_idle", pend, 0);
    beat(1, rep(9), rep(9), 2, 3);
    gap(1);
    chk("err_c_idle", err, 1);
    chk("pend_after_c_idle", pend, 0);
    beat(0, rep(7), '0, 0, 0);
    gap(1);
    chk("pend_a1", pend, 1);
    beat(0, rep(2), '0, 0, 0);
    gap(1);
    chk("pend_a2", pend, 1);
    cbeat(rep(0), rep(5), 9, 9, rep(2), rep(2));
    gap(1);
    chk("pend_c", pend, 0);
    chk("err_sticky", err, 1);
    gap(4);
    for (int i = 0; i < 8; i++) begin
      beat(0, rep(ta[i]), '0, 0, 0);
      cbeat(rep(tc[i]), rep(tl[i]), LW'(i + 1), CW'(i), rep(tu[i]), rep(tlo[i]));
    end
    gap(5);
    chk("queue_drained", q.size(), 0);
    beat(0, rep(5), '0, 0, 0);
    beat(1, rep(3), rep(-7), 3, 2);
    gap(1);
    @(posedge clk);
    #1;
    rst = 0;
    #1;
    chk("mid_w_en", w_en, 0);
    chk("mid_b_wr", |b_wr, 0);
    chk("mid_tags", {layer_w, cnta}, 0);
    chk("mid_pend", pend, 0);
    chk("mid_err", err, 0);
    @(posedge clk);
    #1;
    rst = 1;
    gap(8);
    chk("post_rst_pend", pend, 0);
    chk("post_rst_err", err, 0);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
